// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame controller (state, TX_OUT mux select, parity type).
// Optional parity support is controlled by the UART_TX_PARITY_EN macro in the files that import this package.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_DATA  = 2'd1;
    localparam logic [1:0] SEL_PAR   = 2'd2;
    localparam logic [1:0] SEL_STOP  = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Registered parity bit for one UART frame, captured from the byte and parity type on a load strobe.
// Instantiated by uart_tx_ctrl only when UART_TX_PARITY_EN is defined.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    logic parity_q;
    logic parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = (par_typ == PAR_EVEN) ? (^data) : ~(^data);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign par_bit = parity_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start/data/parity/stop sequencing around an external serializer.
// Define UART_TX_PARITY_EN to build the optional parity bit; otherwise every frame is 10 bits.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DATA_VALID,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SER_EN,
    output logic [DATA_WIDTH-1:0] SER_P_DATA,
    input  logic                  SER_DATA,
    input  logic                  SER_DONE,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state_q, state_d;
    logic                  ser_en_q, ser_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  load;
    logic                  par_bit;
    logic [1:0]            tx_sel;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .CLK    (CLK),
        .RST    (RST),
        .load   (load),
        .data   (P_DATA),
        .par_typ(PAR_TYP),
        .par_bit(par_bit)
    );

    always_comb begin
        par_en_d = load ? PAR_EN : par_en_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{PAR_EN, PAR_TYP};
    assign par_bit    = 1'b0;
`endif

    // A new request is accepted only from IDLE or STOP; STOP acceptance gives back-to-back frames.
    always_comb begin
        state_d  = state_q;
        ser_en_d = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE, STOP: begin
                if (DATA_VALID) begin
                    load     = 1'b1;
                    ser_en_d = 1'b1;
                    state_d  = START;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: state_d = DATA;
            DATA: begin
                if (SER_DONE) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_d = STOP;
`endif
            default: state_d = IDLE;
        endcase
        data_d = load ? P_DATA : data_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            ser_en_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ser_en_q <= ser_en_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx_sel = SEL_START;
            DATA:    tx_sel = SEL_DATA;
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_sel = SEL_PAR;
`endif
            default: tx_sel = SEL_STOP;
        endcase
    end

    always_comb begin
        case (tx_sel)
            SEL_START: TX_OUT = 1'b0;
            SEL_DATA:  TX_OUT = SER_DATA;
            SEL_PAR:   TX_OUT = par_bit;
            default:   TX_OUT = 1'b1;
        endcase
    end

    assign Busy       = (state_q != IDLE);
    assign SER_EN     = ser_en_q;
    assign SER_P_DATA = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural LSB-first serializer; adapts to UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam bit PARITY_BUILD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       DATA_VALID;
    logic [7:0] P_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       SER_EN;
    logic [7:0] SER_P_DATA;
    logic       SER_DATA;
    logic       SER_DONE;
    logic       TX_OUT;
    logic       Busy;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DATA_VALID(DATA_VALID),
        .P_DATA    (P_DATA),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .SER_EN    (SER_EN),
        .SER_P_DATA(SER_P_DATA),
        .SER_DATA  (SER_DATA),
        .SER_DONE  (SER_DONE),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    // Serializer model: loads on the edge where SER_EN is high, then shifts one bit per cycle.
    logic [7:0] ser_sh;
    logic [2:0] ser_cnt;
    logic       ser_act;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_sh  <= 8'h00;
            ser_cnt <= 3'd0;
            ser_act <= 1'b0;
        end else if (SER_EN) begin
            ser_sh  <= SER_P_DATA;
            ser_cnt <= 3'd0;
            ser_act <= 1'b1;
        end else if (ser_act) begin
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt + 3'd1;
            if (ser_cnt == 3'd7) ser_act <= 1'b0;
        end
    end

    assign SER_DATA = ser_sh[0];
    assign SER_DONE = ser_act && (ser_cnt == 3'd7);

    typedef struct packed {
        logic tx;
        logic ser_en;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   idle_chk = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push_frame(input logic [7:0] b, input logic pe, input logic pt);
        logic par;
        par = (^b) ^ pt;
        exp_q.push_back('{tx: 1'b0, ser_en: 1'b1, busy: 1'b1});
        for (int i = 0; i < 8; i++) exp_q.push_back('{tx: b[i], ser_en: 1'b0, busy: 1'b1});
        if (pe && PARITY_BUILD) exp_q.push_back('{tx: par, ser_en: 1'b0, busy: 1'b1});
        exp_q.push_back('{tx: 1'b1, ser_en: 1'b0, busy: 1'b1});
    endtask

    // One cycle: sample at the falling edge against the next expected line state (or idle).
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("tx_out", {31'd0, TX_OUT}, {31'd0, e.tx});
            check_eq("ser_en", {31'd0, SER_EN}, {31'd0, e.ser_en});
            check_eq("busy",   {31'd0, Busy},   {31'd0, e.busy});
        end else if (idle_chk) begin
            check_eq("idle_tx",     {31'd0, TX_OUT}, 32'd1);
            check_eq("idle_busy",   {31'd0, Busy},   32'd0);
            check_eq("idle_ser_en", {31'd0, SER_EN}, 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic pt);
        DATA_VALID = 1'b1;
        P_DATA     = b;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        push_frame(b, pe, pt);
        tick();
        DATA_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check_eq("drain", exp_q.size(), 32'd0);
        $display("frame done: checks so far %0d", n_checks);
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        repeat (2) tick();

        // 0xA5 without parity: 10-cycle frame
        send(8'hA5, 1'b0, 1'b0); drain(); repeat (2) tick();
        // Parity frames: 11 cycles with parity build, 10 otherwise
        send(8'hA5, 1'b1, 1'b0); drain(); repeat (2) tick();
        send(8'hA5, 1'b1, 1'b1); drain(); repeat (2) tick();
        send(8'h07, 1'b1, 1'b0); drain(); repeat (2) tick();

        // Back-to-back 0x55 then 0xFF with DATA_VALID held through the first stop bit
        DATA_VALID = 1'b1; P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        push_frame(8'h55, 1'b0, 1'b0);
        push_frame(8'hFF, 1'b0, 1'b0);
        tick();
        P_DATA = 8'hFF;
        for (int i = 0; i < 20 && exp_q.size() > 10; i++) tick();
        tick();
        DATA_VALID = 1'b0;
        drain(); repeat (2) tick();

        // Request during DATA is ignored
        send(8'h3C, 1'b0, 1'b0);
        repeat (3) tick();
        DATA_VALID = 1'b1; P_DATA = 8'h00;
        tick();
        DATA_VALID = 1'b0;
        check_eq("latched_byte", {24'd0, SER_P_DATA}, 32'h3C);
        drain(); repeat (3) tick();

        // Asynchronous reset mid-DATA returns the line high before the next edge
        send(8'hA5, 1'b0, 1'b0);
        repeat (4) tick();
        #2 RST = 1'b0;
        #1;
        check_eq("rst_tx",     {31'd0, TX_OUT}, 32'd1);
        check_eq("rst_busy",   {31'd0, Busy},   32'd0);
        check_eq("rst_ser_en", {31'd0, SER_EN}, 32'd0);
        exp_q.delete();
        tick();
        RST = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
